// File: rtl/threewire_slave.sv
// threewire_slave: responder for the three-wire serial bus (active-low cs,
// master clock, one bidirectional data line). Decodes R/W + address + data
// frames into a write strobe or a read request, and shifts read data back.
// All bus pins are oversampled and synchronised into the in_clk domain.
`timescale 1ns/1ps
module threewire_slave #(
    parameter int ADDR_BITS   = 9,
    parameter int DATA_BITS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_tw_clock,
    input  logic                 in_tw_cs,
    inout  wire                  io_tw_data,
    output logic                 out_tw_oe,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic [DATA_BITS-1:0] out_wr_data,
    output logic                 out_wr_strobe,
    output logic                 out_rd_req,
    input  logic [DATA_BITS-1:0] in_rd_data,
    output logic                 out_busy,
    output logic                 out_frame_err
);

    localparam int RX_W  = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
    localparam int CNT_W = $clog2(RX_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RW,
        S_ADDR,
        S_WDATA,
        S_TURN,
        S_RDATA,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   r_is_write;
    logic [CNT_W-1:0]       r_cnt;
    logic [RX_W-2:0]        r_rx;
    logic [DATA_BITS-1:0]   r_tx;
    logic                   r_tx_bit;
    logic                   r_oe;
    logic                   r_busy;
    logic                   r_strobe_pend;
    logic                   r_wr_strobe;
    logic                   r_rd_req;
    logic                   r_frame_err;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DATA_BITS-1:0]   r_wr_data;

    logic                   w_clk_s;
    logic                   w_cs_s;
    logic                   w_dat_s;
    logic                   w_rise;
    logic                   w_abort;
    logic [RX_W-1:0]        w_rx_next;

    assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_dat_s   = r_dat_sync[SYNC_STAGES-1];
    assign w_rise    = w_clk_s & ~r_clk_prev;
    // cs going high before the frame finished is an abort; DONE/IDLE are the
    // only states where a high cs is legitimate.
    assign w_abort   = w_cs_s && (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_rx_next = {r_rx, w_dat_s};

    // Releasing the line must not wait for the registered state update on abort.
    assign out_tw_oe     = r_oe & ~w_abort;
    assign io_tw_data    = out_tw_oe ? r_tx_bit : 1'bz;
    assign out_addr      = r_addr;
    assign out_wr_data   = r_wr_data;
    assign out_wr_strobe = r_wr_strobe;
    assign out_rd_req    = r_rd_req;
    assign out_busy      = r_busy;
    assign out_frame_err = r_frame_err;

    // Synchronise the bus pins, preset to idle bus levels (cs high, clock low).
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_clk_sync <= '0;
            r_cs_sync  <= '1;
            r_dat_sync <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], in_tw_clock};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], in_tw_cs};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], io_tw_data};
            r_clk_prev <= w_clk_s;
        end
    end

    // Frame FSM: decodes R/W, address and data on synced tw clock rising edges.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state       <= S_IDLE;
            r_is_write    <= 1'b0;
            r_cnt         <= '0;
            r_rx          <= '0;
            r_tx          <= '0;
            r_tx_bit      <= 1'b0;
            r_oe          <= 1'b0;
            r_busy        <= 1'b0;
            r_strobe_pend <= 1'b0;
            r_wr_strobe   <= 1'b0;
            r_rd_req      <= 1'b0;
            r_frame_err   <= 1'b0;
            r_addr        <= '0;
            r_wr_data     <= '0;
        end else begin
            // Strobe trails the data register update by one cycle.
            r_wr_strobe   <= r_strobe_pend;
            r_strobe_pend <= 1'b0;
            r_rd_req      <= 1'b0;
            r_frame_err   <= 1'b0;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_oe        <= 1'b0;
                r_busy      <= 1'b0;
                r_frame_err <= 1'b1;
                r_cnt       <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_cs_s) begin
                            r_state <= S_RW;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                    S_RW: begin
                        if (w_rise) begin
                            r_is_write <= w_dat_s;
                            r_state    <= S_ADDR;
                            r_cnt      <= '0;
                        end
                    end
                    S_ADDR: begin
                        if (w_rise) begin
                            r_rx <= w_rx_next[RX_W-2:0];
                            if (r_cnt == CNT_W'(ADDR_BITS - 1)) begin
                                r_addr <= w_rx_next[ADDR_BITS-1:0];
                                r_cnt  <= '0;
                                if (r_is_write) begin
                                    r_state <= S_WDATA;
                                end else begin
                                    r_rd_req <= 1'b1;
                                    r_state  <= S_TURN;
                                end
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_rise) begin
                            r_rx <= w_rx_next[RX_W-2:0];
                            if (r_cnt == CNT_W'(DATA_BITS - 1)) begin
                                r_wr_data     <= w_rx_next[DATA_BITS-1:0];
                                r_strobe_pend <= 1'b1;
                                r_cnt         <= '0;
                                r_state       <= S_DONE;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_TURN: begin
                        // Line is enabled here but still carries the previous bit.
                        if (w_rise) begin
                            r_tx    <= in_rd_data;
                            r_oe    <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_RDATA;
                        end
                    end
                    S_RDATA: begin
                        if (w_rise) begin
                            if (r_cnt == CNT_W'(DATA_BITS)) begin
                                r_oe    <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_tx_bit <= r_tx[DATA_BITS-1];
                                r_tx     <= {r_tx[DATA_BITS-2:0], 1'b0};
                                r_cnt    <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (w_cs_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_threewire_slave.sv
// tb_threewire_slave: master-side bus driver plus a register-file model for
// threewire_slave; directed and random frames checked with immediate asserts.
`timescale 1ns/1ps
module tb_threewire_slave;

    localparam int AB   = 9;
    localparam int DB   = 16;
    localparam int SS   = 2;
    localparam int HALF = 8;   // in_clk cycles per half bus period

    logic          in_clk = 1'b0;
    logic          in_rst = 1'b0;
    logic          tw_clk = 1'b0;
    logic          tw_cs  = 1'b1;
    logic          m_oe   = 1'b0;
    logic          m_data = 1'b0;
    logic [DB-1:0] in_rd_data = '0;
    wire           io_tw_data;

    logic          out_tw_oe;
    logic [AB-1:0] out_addr;
    logic [DB-1:0] out_wr_data;
    logic          out_wr_strobe;
    logic          out_rd_req;
    logic          out_busy;
    logic          out_frame_err;

    assign io_tw_data = m_oe ? m_data : 1'bz;

    threewire_slave #(.ADDR_BITS(AB), .DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_tw_clock   (tw_clk),
        .in_tw_cs      (tw_cs),
        .io_tw_data    (io_tw_data),
        .out_tw_oe     (out_tw_oe),
        .out_addr      (out_addr),
        .out_wr_data   (out_wr_data),
        .out_wr_strobe (out_wr_strobe),
        .out_rd_req    (out_rd_req),
        .in_rd_data    (in_rd_data),
        .out_busy      (out_busy),
        .out_frame_err (out_frame_err)
    );

    always #5 in_clk = ~in_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Event tallies gathered away from the active edge.
    int            cnt_strobe = 0;
    int            cnt_rdreq  = 0;
    int            cnt_err    = 0;
    int            cnt_oe     = 0;
    logic [AB-1:0] strobe_addr = '0;
    logic [DB-1:0] strobe_data = '0;
    logic [AB-1:0] rdreq_addr  = '0;

    // Reference model: the local register file and expected output registers.
    logic [DB-1:0] mem [0:(1<<AB)-1];
    logic [AB-1:0] exp_addr = '0;
    logic [DB-1:0] exp_wr   = '0;

    always @(negedge in_clk) begin
        if (out_wr_strobe) begin
            cnt_strobe++;
            strobe_addr = out_addr;
            strobe_data = out_wr_data;
        end
        if (out_rd_req) begin
            cnt_rdreq++;
            rdreq_addr = out_addr;
            in_rd_data = mem[out_addr];
        end
        if (out_frame_err) cnt_err++;
        if (out_tw_oe)     cnt_oe++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus clock pulse; returns the line as seen just before the falling edge.
    task automatic tw_pulse(output logic s);
        repeat (HALF) @(negedge in_clk);
        tw_clk = 1'b1;
        repeat (HALF) @(negedge in_clk);
        s = io_tw_data;
        tw_clk = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        logic d;
        m_oe   = 1'b1;
        m_data = b;
        tw_pulse(d);
    endtask

    task automatic frame(input logic is_wr, input logic [AB-1:0] addr, input logic [DB-1:0] data,
                         input int extra, input int gap, input string tag);
        int            s0 = cnt_strobe;
        int            r0 = cnt_rdreq;
        int            e0 = cnt_err;
        int            o0 = cnt_oe;
        logic [DB-1:0] rd = '0;
        logic          s;
        tw_cs = 1'b0;
        repeat (4) @(negedge in_clk);
        check({tag, "_busy_hi"}, 32'(out_busy), 32'd1);
        send_bit(is_wr);
        for (int i = 0; i < AB; i++) send_bit(addr[AB-1-i]);
        if (is_wr) begin
            for (int i = 0; i < DB; i++) send_bit(data[DB-1-i]);
        end else begin
            m_oe = 1'b0;
            tw_pulse(s);                       // turnaround
            for (int i = 0; i < DB; i++) begin
                tw_pulse(s);
                rd = {rd[DB-2:0], s};
            end
            tw_pulse(s);                       // release
        end
        for (int i = 0; i < extra; i++) tw_pulse(s);
        repeat (HALF) @(negedge in_clk);
        m_oe  = 1'b0;
        tw_cs = 1'b1;
        repeat (gap) @(negedge in_clk);
        exp_addr = addr;
        if (is_wr) begin
            exp_wr    = data;
            mem[addr] = data;
        end
        check({tag, "_strobes"}, 32'(cnt_strobe - s0), is_wr ? 32'd1 : 32'd0);
        check({tag, "_rdreqs"},  32'(cnt_rdreq - r0),  is_wr ? 32'd0 : 32'd1);
        check({tag, "_errs"},    32'(cnt_err - e0),    32'd0);
        check({tag, "_addr"},    32'(out_addr),        32'(exp_addr));
        check({tag, "_wrdata"},  32'(out_wr_data),     32'(exp_wr));
        check({tag, "_busy_lo"}, 32'(out_busy),        32'd0);
        check({tag, "_oe_off"},  32'(out_tw_oe),       32'd0);
        if (is_wr) begin
            check({tag, "_oe_never"}, 32'(cnt_oe - o0), 32'd0);
            check({tag, "_stb_addr"}, 32'(strobe_addr), 32'(addr));
            check({tag, "_stb_data"}, 32'(strobe_data), 32'(data));
        end else begin
            check({tag, "_oe_seen"},  32'(cnt_oe > o0),  32'd1);
            check({tag, "_rq_addr"},  32'(rdreq_addr),   32'(addr));
            check({tag, "_rd_word"},  32'(rd),           32'(mem[addr]));
        end
        $display("frame %s: %s addr=0x%03h data=0x%04h rd=0x%04h", tag,
                 is_wr ? "WR" : "RD", addr, is_wr ? data : mem[addr], rd);
    endtask

    initial begin
        logic          s;
        logic [AB-1:0] a;
        int            e0, s0, r0;
        for (int i = 0; i < (1 << AB); i++) mem[i] = DB'($urandom);
        mem[9'h155] = 16'h00CA;
        mem[9'h000] = 16'h8001;

        // Reset state
        repeat (3) @(negedge in_clk);
        check("rst_oe",     32'(out_tw_oe),     32'd0);
        check("rst_addr",   32'(out_addr),      32'd0);
        check("rst_wrdata", 32'(out_wr_data),   32'd0);
        check("rst_busy",   32'(out_busy),      32'd0);
        check("rst_pulses", 32'({out_wr_strobe, out_rd_req, out_frame_err}), 32'd0);
        in_rst = 1'b1;
        repeat (4) @(negedge in_clk);

        // Directed write and read
        frame(1'b1, 9'h0A3, 16'hBEEF, 0, 6, "wr_0a3");
        frame(1'b0, 9'h155, 16'h0000, 0, 6, "rd_155");

        // Abort after 5 address bits
        e0 = cnt_err; s0 = cnt_strobe; r0 = cnt_rdreq;
        tw_cs = 1'b0;
        repeat (4) @(negedge in_clk);
        send_bit(1'b1);
        a = 9'h1B6;
        for (int i = 0; i < 5; i++) send_bit(a[AB-1-i]);
        m_oe  = 1'b0;
        tw_cs = 1'b1;
        repeat (SS + 2) @(negedge in_clk);
        check("abort_err",     32'(cnt_err - e0),    32'd1);
        check("abort_strobe",  32'(cnt_strobe - s0), 32'd0);
        check("abort_rdreq",   32'(cnt_rdreq - r0),  32'd0);
        check("abort_busy",    32'(out_busy),        32'd0);
        check("abort_addr",    32'(out_addr),        32'(exp_addr));
        check("abort_wrdata",  32'(out_wr_data),     32'(exp_wr));
        $display("frame abort: cs raised after 5 address bits");
        repeat (4) @(negedge in_clk);

        // Reset during RDATA bit 7
        tw_cs = 1'b0;
        repeat (4) @(negedge in_clk);
        send_bit(1'b0);
        a = 9'h0F0;
        for (int i = 0; i < AB; i++) send_bit(a[AB-1-i]);
        m_oe = 1'b0;
        tw_pulse(s);
        for (int i = 0; i < 8; i++) tw_pulse(s);
        repeat (HALF) @(negedge in_clk);
        tw_clk = 1'b1;
        repeat (5) @(negedge in_clk);
        check("rdata_oe_on", 32'(out_tw_oe), 32'd1);
        in_rst = 1'b0;
        #1;
        exp_addr = '0;
        exp_wr   = '0;
        check("midrst_oe",     32'(out_tw_oe),   32'd0);
        check("midrst_busy",   32'(out_busy),    32'd0);
        check("midrst_addr",   32'(out_addr),    32'd0);
        check("midrst_wrdata", 32'(out_wr_data), 32'd0);
        $display("frame reset: in_rst asserted during read bit 7");
        @(negedge in_clk);
        tw_clk = 1'b0;
        tw_cs  = 1'b1;
        repeat (3) @(negedge in_clk);
        in_rst = 1'b1;
        repeat (4) @(negedge in_clk);
        frame(1'b1, 9'h001, 16'h1234, 0, 6, "wr_after_rst");

        // Back-to-back frames, cs high 6 cycles
        frame(1'b1, 9'h1FF, 16'hFFFF, 0, 6, "b2b_wr");
        frame(1'b0, 9'h000, 16'h0000, 0, 6, "b2b_rd");

        // Extra clocks after a write
        frame(1'b1, 9'h07C, 16'h5A3C, 3, 6, "wr_extra");

        // Random frames against the register-file model
        for (int i = 0; i < 6; i++) begin
            frame(1'($urandom_range(0, 1)), AB'($urandom), DB'($urandom),
                  int'($urandom_range(0, 2)), 6 + int'($urandom_range(0, 3)),
                  $sformatf("rnd%0d", i));
        end
        // Read back a random-written location
        frame(1'b0, exp_addr, 16'h0000, 0, 6, "rd_back");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
